tmds_channel_decoder: RTL and testbench

- Receive-side counterpart of the per-channel TMDS encoder in the DVI transmitter.
- Accepts one 10-bit parallel TMDS word per pixel clock from an external 1:10 deserializer.
- Achieves word alignment by searching for control-token runs and pulsing a bitslip request to the deserializer.
- Once locked, decodes each word to 8-bit pixel data (active video) or a 2-bit control value (blanking: hsync/vsync on the blue channel).
- One instance per TMDS channel; three instances form the receive path of an HDMI-in pipeline.

---
 rtl/tmds_channel_decoder.sv | 178 +++++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_decoder.sv
// rtl/tmds_channel_decoder.sv - TMDS receive channel: word alignment and 10b->8b decode
//
// Ports:
//   pix_clk   in   pixel clock, rising edge
//   rstn      in   asynchronous active-low reset
//   tmds_din  in   10-bit deserialized TMDS word, bit 0 first on the wire
//   bitslip   out  one-cycle request to rotate the deserializer word boundary by one bit
//   aligned   out  high while locked to the word boundary
//   de_out    out  decoded data enable
//   ctrl_out  out  decoded control bits {c1,c0}
//   data_out  out  decoded pixel byte

module tmds_channel_decoder #(
  parameter int CTRL_RUN   = 8,
  parameter int SEARCH_WIN = 4096,
  parameter int SLIP_WAIT  = 16,
  parameter int LOSS_WIN   = 4096
) (
  input  logic       pix_clk,
  input  logic       rstn,
  input  logic [9:0] tmds_din,
  output logic       bitslip,
  output logic       aligned,
  output logic       de_out,
  output logic [1:0] ctrl_out,
  output logic [7:0] data_out
);

  localparam int WIN_MAX = (SEARCH_WIN > LOSS_WIN) ? SEARCH_WIN : LOSS_WIN;
  localparam int RUN_W   = $clog2(CTRL_RUN + 1);
  localparam int WIN_W   = $clog2(WIN_MAX + 1);
  localparam int WAIT_W  = $clog2(SLIP_WAIT + 1);

  localparam logic [RUN_W-1:0]  RUN_FULL    = RUN_W'(CTRL_RUN);
  localparam logic [WIN_W-1:0]  SEARCH_LAST = WIN_W'(SEARCH_WIN - 1);
  localparam logic [WIN_W-1:0]  LOSS_LAST   = WIN_W'(LOSS_WIN - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(SLIP_WAIT - 1);

  typedef enum logic [1:0] {
    S_SEARCH,
    S_SLIP,
    S_WAIT,
    S_LOCKED
  } state_t;

  state_t            state;
  logic [9:0]        w;
  logic [RUN_W-1:0]  run_cnt;
  logic [WIN_W-1:0]  win_cnt;
  logic [WAIT_W-1:0] wait_cnt;

  logic              is_tok;
  logic [1:0]        tok_val;
  logic [8:0]        q;
  logic [7:0]        dec;
  logic [RUN_W-1:0]  run_next;
  logic              lock_hit;

  // Control token recognition on the stage-1 word.
  always_comb begin
    is_tok  = 1'b1;
    tok_val = 2'b00;
    case (w)
      10'h354: tok_val = 2'b00;
      10'h0AB: tok_val = 2'b01;
      10'h154: tok_val = 2'b10;
      10'h2AB: tok_val = 2'b11;
      default: is_tok = 1'b0;
    endcase
  end

  // Undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8 selects).
  always_comb begin
    q      = w[9] ? {w[8], ~w[7:0]} : w[8:0];
    dec    = 8'h00;
    dec[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = q[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

  always_comb begin
    if (!is_tok) begin
      run_next = '0;
    end else if (run_cnt == RUN_FULL) begin
      run_next = run_cnt;
    end else begin
      run_next = run_cnt + 1'b1;
    end
  end

  // Lock is taken on the edge that decodes the completing token, so that
  // word's outputs and aligned appear together.
  assign lock_hit = (run_next == RUN_FULL);

  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_SEARCH;
      w        <= '0;
      run_cnt  <= '0;
      win_cnt  <= '0;
      wait_cnt <= '0;
      bitslip  <= 1'b0;
      aligned  <= 1'b0;
      de_out   <= 1'b0;
      ctrl_out <= 2'b00;
      data_out <= 8'h00;
    end else begin
      w       <= tmds_din;
      bitslip <= 1'b0;
      case (state)
        S_SEARCH: begin
          run_cnt <= run_next;
          if (lock_hit) begin
            state    <= S_LOCKED;
            win_cnt  <= '0;
            aligned  <= 1'b1;
            de_out   <= 1'b0;
            ctrl_out <= tok_val;
            data_out <= 8'h00;
          end else if (win_cnt == SEARCH_LAST) begin
            state   <= S_SLIP;
            bitslip <= 1'b1;
          end else begin
            win_cnt <= win_cnt + 1'b1;
          end
        end

        S_SLIP: begin
          state    <= S_WAIT;
          run_cnt  <= '0;
          win_cnt  <= '0;
          wait_cnt <= '0;
        end

        // Deserializer settling time: incoming words are meaningless here.
        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state    <= S_SEARCH;
            wait_cnt <= '0;
            run_cnt  <= '0;
            win_cnt  <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_LOCKED: begin
          run_cnt <= run_next;
          if (!is_tok && (win_cnt == LOSS_LAST)) begin
            // Too long without blanking: re-search from the current boundary.
            state    <= S_SEARCH;
            run_cnt  <= '0;
            win_cnt  <= '0;
            aligned  <= 1'b0;
            de_out   <= 1'b0;
            ctrl_out <= 2'b00;
            data_out <= 8'h00;
          end else if (is_tok) begin
            win_cnt  <= '0;
            de_out   <= 1'b0;
            ctrl_out <= tok_val;
            data_out <= 8'h00;
          end else begin
            win_cnt  <= win_cnt + 1'b1;
            de_out   <= 1'b1;
            data_out <= dec;
          end
        end

        default: begin
          state <= S_SEARCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb/tb_tmds_channel_decoder.sv - scoreboard bench for tmds_channel_decoder

module tb_tmds_channel_decoder;

  logic       pix_clk;
  logic       rstn;
  logic [9:0] tmds_din;
  logic       bitslip;
  logic       aligned;
  logic       de_out;
  logic [1:0] ctrl_out;
  logic [7:0] data_out;

  tmds_channel_decoder dut (
    .pix_clk  (pix_clk),
    .rstn     (rstn),
    .tmds_din (tmds_din),
    .bitslip  (bitslip),
    .aligned  (aligned),
    .de_out   (de_out),
    .ctrl_out (ctrl_out),
    .data_out (data_out)
  );

  initial pix_clk = 1'b0;
  always #5 pix_clk = ~pix_clk;

  typedef struct {
    int         due;
    bit         at_reset;
    string      name;
    logic       al;
    logic       de;
    logic       sl;
    logic [1:0] ct;
    logic [7:0] dt;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge pix_clk) cyc = cyc + 1;

  task automatic check_entry(input exp_t e);
    checks = checks + 1;
    if (aligned !== e.al || de_out !== e.de || bitslip !== e.sl ||
        ctrl_out !== e.ct || data_out !== e.dt) begin
      errors = errors + 1;
      $display("FAIL %s cyc=%0d got al=%b de=%b slip=%b ctrl=%b data=%h want al=%b de=%b slip=%b ctrl=%b data=%h",
               e.name, cyc, aligned, de_out, bitslip, ctrl_out, data_out,
               e.al, e.de, e.sl, e.ct, e.dt);
    end
  endtask

  // Cycle monitor: compare every expectation that falls due at this cycle.
  always @(negedge pix_clk) begin
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (!sb[i].at_reset && sb[i].due == cyc) begin
        check_entry(sb[i]);
        sb.delete(i);
      end else if (!sb[i].at_reset && sb[i].due < cyc) begin
        errors = errors + 1;
        $display("FAIL stale_%s due=%0d cyc=%0d", sb[i].name, sb[i].due, cyc);
        sb.delete(i);
      end else begin
        i = i + 1;
      end
    end
  end

  // Asynchronous reset monitor: outputs must clear without a clock edge.
  always @(negedge rstn) begin
    int i;
    #1;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].at_reset) begin
        check_entry(sb[i]);
        sb.delete(i);
      end else begin
        i = i + 1;
      end
    end
  end

  task automatic push(input int due, input bit at_reset, input string nm,
                      input logic al, input logic de, input logic sl,
                      input logic [1:0] ct, input logic [7:0] dt);
    exp_t e;
    e.due = due; e.at_reset = at_reset; e.name = nm;
    e.al = al; e.de = de; e.sl = sl; e.ct = ct; e.dt = dt;
    sb.push_back(e);
  endtask

  // Drive one word; its decoded result is due two edges later.
  task automatic drive(input logic [9:0] word, input string nm,
                       input logic al, input logic de, input logic sl,
                       input logic [1:0] ct, input logic [7:0] dt);
    @(negedge pix_clk);
    tmds_din = word;
    push(cyc + 2, 1'b0, nm, al, de, sl, ct, dt);
  endtask

  int r;
  int n;

  initial begin
    rstn     = 1'b0;
    tmds_din = 10'h000;

    // Reset with random input words.
    for (int k = 0; k < 6; k++) drive(10'($urandom_range(0, 1023)), "reset", 0, 0, 0, 2'b00, 8'h00);
    @(negedge pix_clk);
    rstn = 1'b1;
    r    = cyc;
    push(cyc + 2, 1'b0, "post_release", 0, 0, 0, 2'b00, 8'h00);

    // Misaligned stream: pulses 4096 and 4096+1+16+4096 edges after release.
    for (int k = 1; k <= 8207; k++) begin
      n = k + 2;
      drive(10'h1A9, "slip", 0, 0, ((n == 4096) || (n == 8209)) ? 1'b1 : 1'b0, 2'b00, 8'h00);
    end
    @(negedge pix_clk);
    @(negedge pix_clk);
    #2;
    push(0, 1'b1, "mid_pulse_reset", 0, 0, 0, 2'b00, 8'h00);
    rstn = 1'b0;

    for (int k = 0; k < 3; k++) drive(10'($urandom_range(0, 1023)), "reset2", 0, 0, 0, 2'b00, 8'h00);
    @(negedge pix_clk);
    rstn = 1'b1;
    push(cyc + 2, 1'b0, "post_release2", 0, 0, 0, 2'b00, 8'h00);

    // Lock on eight 0x354 tokens.
    for (int k = 1; k <= 7; k++) drive(10'h354, "lock_run", 0, 0, 0, 2'b00, 8'h00);
    drive(10'h354, "lock_8th", 1, 0, 0, 2'b00, 8'h00);

    // Decode vectors while locked.
    drive(10'h100, "dec_100", 1, 1, 0, 2'b00, 8'h00);
    drive(10'h2FF, "dec_2ff", 1, 1, 0, 2'b00, 8'hFE);
    drive(10'h0AB, "tok_0ab", 1, 0, 0, 2'b01, 8'h00);
    drive(10'h155, "dec_155", 1, 1, 0, 2'b01, 8'hFF);
    drive(10'h1FF, "dec_1ff", 1, 1, 0, 2'b01, 8'h01);
    drive(10'h154, "tok_154", 1, 0, 0, 2'b10, 8'h00);

    // 4096 data words after the last token drop lock.
    for (int k = 1; k <= 4095; k++) drive(10'h100, "loss_hold", 1, 1, 0, 2'b10, 8'h00);
    drive(10'h100, "loss_drop", 0, 0, 0, 2'b00, 8'h00);

    // Relock on 0x2AB tokens.
    for (int k = 1; k <= 7; k++) drive(10'h2AB, "relock_run", 0, 0, 0, 2'b00, 8'h00);
    drive(10'h2AB, "relock_8th", 1, 0, 0, 2'b11, 8'h00);
    drive(10'h100, "relock_data", 1, 1, 0, 2'b11, 8'h00);

    for (int k = 0; k < 8 && sb.size() != 0; k++) @(negedge pix_clk);
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain pending=%0d want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors = errors + 1;
    $display("FAIL watchdog cyc=%0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
